// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - RV32I func3 width codes
//   - state enumeration of the access sequencer
//   - small helpers that classify a request (legality, crossing)
package lsu_pkg;

    // RV32I load/store width codes (func3). Bits [1:0] give the access
    // size (00 byte, 01 half, 10 word); bit 2 selects zero-extension.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    // Unsigned widths only exist for loads; 011/110/111 are never legal.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!is_store) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    // An access needs a second memory word when its bytes run past lane 3.
    function automatic logic access_crosses(input logic [1:0] size, input logic [1:0] offset);
        return ((size == SZ_W) && (offset != 2'd0)) ||
               ((size == SZ_H) && (offset == 2'd3));
    endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Byte-lane alignment shared by the store and load paths.
//   Store side: right-justified st_data is masked to the access size and
//   shifted up to byte offset 'offset' across a 64-bit window; the low half
//   (st_lo/be_lo) goes to the first word, the overflow (st_hi/be_hi) to the
//   next word starting at lane 0.
//   Load side: the two fetched words {ld_hi, ld_lo} are shifted down by
//   'offset' bytes and the result is sign- or zero-extended to 32 bits.
// Ports
//   offset     in   byte offset within the first word
//   size       in   access size (SZ_B / SZ_H / SZ_W)
//   sign_ext   in   1 = sign-extend loads, 0 = zero-extend
//   st_data    in   store data, right-justified
//   st_lo/hi   out  lane-aligned store data for first/second word
//   be_lo/hi   out  byte enables for first/second word
//   ld_lo/hi   in   first/second fetched word
//   ld_data    out  assembled, extended load result
module byte_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] st_data,
    output logic [31:0] st_lo,
    output logic [31:0] st_hi,
    output logic [3:0]  be_lo,
    output logic [3:0]  be_hi,
    input  logic [31:0] ld_lo,
    input  logic [31:0] ld_hi,
    output logic [31:0] ld_data
);

    logic [31:0] data_mask;
    logic [3:0]  lane_mask;
    logic [63:0] st_wide;
    logic [7:0]  be_wide;
    logic [63:0] ld_wide;
    logic [31:0] ld_raw;

    // NOTE: every signal written in a combinational block gets a default
    // first; a path that skips an assignment would otherwise infer a latch.
    always_comb begin
        data_mask = 32'hFFFF_FFFF;
        lane_mask = 4'b1111;
        case (size)
            SZ_B: begin
                data_mask = 32'h0000_00FF;
                lane_mask = 4'b0001;
            end
            SZ_H: begin
                data_mask = 32'h0000_FFFF;
                lane_mask = 4'b0011;
            end
            default: ;
        endcase

        // Unused lanes carry zeros rather than stray upper bytes of wdata.
        st_wide = {32'h0, st_data & data_mask} << {offset, 3'b000};
        be_wide = {4'h0, lane_mask} << offset;
        st_lo   = st_wide[31:0];
        st_hi   = st_wide[63:32];
        be_lo   = be_wide[3:0];
        be_hi   = be_wide[7:4];

        ld_wide = {ld_hi, ld_lo} >> {offset, 3'b000};
        ld_raw  = ld_wide[31:0];
        case (size)
            SZ_B:    ld_data = {{24{sign_ext & ld_raw[7]}},  ld_raw[7:0]};
            SZ_H:    ld_data = {{16{sign_ext & ld_raw[15]}}, ld_raw[15:0]};
            default: ld_data = ld_raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a pipeline and a word-wide data memory.
// Accepts one B/H/W (and BU/HU for loads) access at a time, performs one
// memory cycle, or two when the access straddles a word boundary, and
// reports completion with a one-cycle done pulse.
// Ports
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_write            1 = store, 0 = load
//   func3                RV32I width code
//   addr                 byte address
//   wdata                store data, right-justified
//   rdata, done, err     extended load result, completion pulse, illegal flag
//   mem_read/mem_write   memory enables
//   mem_addr             memory word address
//   mem_be, mem_wdata    byte enables and lane-aligned write data
//   mem_rdata            combinational read data for mem_addr
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WORD_ADDR_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [2:0]               func3,
    input  logic [WORD_ADDR_W+1:0]   addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic                     done,
    output logic                     err,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [WORD_ADDR_W-1:0]   mem_addr,
    output logic [3:0]               mem_be,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata
);

    lsu_state_e                 state_q, state_d;
    logic                       write_q, write_d;
    logic [2:0]                 func3_q, func3_d;
    logic [WORD_ADDR_W+1:0]     addr_q, addr_d;
    logic [31:0]                wdata_q, wdata_d;
    logic [31:0]                rd_lo_q, rd_lo_d;
    logic [31:0]                rd_hi_q, rd_hi_d;

    logic                       legal;
    logic [1:0]                 size;
    logic                       crosses;
    logic [WORD_ADDR_W-1:0]     word_addr;
    logic [WORD_ADDR_W-1:0]     next_word_addr;
    logic [31:0]                st_lo, st_hi, ld_data;
    logic [3:0]                 be_lo, be_hi;

    // Request classification is taken from the captured copy so the live
    // inputs can change freely once the request has been accepted.
    assign legal          = f3_legal(func3_q, write_q);
    assign size           = func3_q[1:0];
    assign crosses        = legal && access_crosses(size, addr_q[1:0]);
    assign word_addr      = addr_q[WORD_ADDR_W+1:2];
    // Wraps from the last word back to word 0.
    assign next_word_addr = word_addr + {{(WORD_ADDR_W-1){1'b0}}, 1'b1};

    byte_lane_align u_align (
        .offset   (addr_q[1:0]),
        .size     (size),
        .sign_ext (~func3_q[2]),
        .st_data  (wdata_q),
        .st_lo    (st_lo),
        .st_hi    (st_hi),
        .be_lo    (be_lo),
        .be_hi    (be_hi),
        .ld_lo    (rd_lo_q),
        .ld_hi    (rd_hi_q),
        .ld_data  (ld_data)
    );

    // Next-state and capture logic.
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        func3_d = func3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_lo_d = rd_lo_q;
        rd_hi_d = rd_hi_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    func3_d = func3;
                    addr_d  = addr;
                    wdata_d = wdata;
                    state_d = ACC1;
                end
            end
            ACC1: begin
                if (!write_q) rd_lo_d = mem_rdata;
                state_d = crosses ? ACC2 : RESP;
            end
            ACC2: begin
                if (!write_q) rd_hi_d = mem_rdata;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs. Everything except req_ready is forced low while rst is high,
    // so a reset landing in ACC2 suppresses the second write at once.
    always_comb begin
        req_ready = (state_q == IDLE);
        done      = 1'b0;
        err       = 1'b0;
        rdata     = 32'h0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_be    = 4'h0;
        mem_wdata = 32'h0;
        if (!rst) begin
            case (state_q)
                ACC1: begin
                    if (legal) begin
                        mem_addr = word_addr;
                        if (write_q) begin
                            mem_write = 1'b1;
                            mem_be    = be_lo;
                            mem_wdata = st_lo;
                        end else begin
                            mem_read  = 1'b1;
                        end
                    end
                end
                ACC2: begin
                    mem_addr = next_word_addr;
                    if (write_q) begin
                        mem_write = 1'b1;
                        mem_be    = be_hi;
                        mem_wdata = st_hi;
                    end else begin
                        mem_read  = 1'b1;
                    end
                end
                RESP: begin
                    done  = 1'b1;
                    err   = ~legal;
                    rdata = (legal && !write_q) ? ld_data : 32'h0;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its _d input, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            func3_q <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rd_lo_q <= 32'h0;
            rd_hi_q <= 32'h0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            func3_q <= func3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_lo_q <= rd_lo_d;
            rd_hi_q <= rd_hi_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 64-word byte-enabled memory
// model attached to the memory port.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  func3;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    // Memory model with a backdoor port for preloading words.
    logic [31:0] mem [64] = '{default: 32'h0};
    logic        bd_we = 1'b0;
    logic [5:0]  bd_addr = 6'd0;
    logic [31:0] bd_data = 32'h0;

    // Per-cycle record of the memory port during the last operation.
    logic [5:0]  cyc_addr [8];
    logic [3:0]  cyc_be   [8];
    logic [31:0] cyc_wd   [8];

    int          lat, nrd, nwr;
    logic [31:0] rd;
    logic        er;
    logic        rdy_at_done;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (mem_write) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    load_store_unit #(.WORD_ADDR_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .func3     (func3),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .done      (done),
        .err       (err),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    // Issues one request and follows it until done (at most 6 cycles).
    // Cycle 1 is the cycle right after the accepting edge; lat is the cycle
    // in which done is seen, 0 if it never came. With hold set, req_valid
    // stays high with different inputs until the cycle after done.
    task automatic run_op(input logic wr, input logic [2:0] f3, input logic [7:0] a,
                          input logic [31:0] wd, input bit hold);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_req", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_write = wr;
        func3     = f3;
        addr      = a;
        wdata     = wd;
        lat = 0; nrd = 0; nwr = 0; rd = 32'hx; er = 1'bx; rdy_at_done = 1'bx;
        for (int k = 0; k < 8; k++) begin
            cyc_addr[k] = 6'h0; cyc_be[k] = 4'h0; cyc_wd[k] = 32'h0;
        end
        @(posedge clk);
        #1;
        if (hold) begin
            func3 = 3'b000;
            addr  = 8'h04;
            wdata = 32'h0;
        end else begin
            req_valid = 1'b0;
        end
        for (int c = 1; c <= 6; c++) begin
            if (mem_read)  nrd++;
            if (mem_write) nwr++;
            cyc_addr[c] = mem_addr;
            cyc_be[c]   = mem_be;
            cyc_wd[c]   = mem_wdata;
            if (done) begin
                lat         = c;
                rd          = rdata;
                er          = err;
                rdy_at_done = req_ready;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (hold) begin
            @(posedge clk);
            #1;
            check("hold_ready_after_resp", {31'h0, req_ready}, 32'h1);
            req_valid = 1'b0;
        end
    endtask

    initial begin
        int pulses;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        func3     = 3'b000;
        addr      = 8'h00;
        wdata     = 32'h0;

        // Reset values.
        @(posedge clk);
        @(negedge clk);
        check("rst_done",      {31'h0, done},      32'h0);
        check("rst_err",       {31'h0, err},       32'h0);
        check("rst_rdata",     rdata,              32'h0);
        check("rst_mem_read",  {31'h0, mem_read},  32'h0);
        check("rst_mem_write", {31'h0, mem_write}, 32'h0);
        check("rst_mem_addr",  {26'h0, mem_addr},  32'h0);
        check("rst_mem_be",    {28'h0, mem_be},    32'h0);
        check("rst_mem_wdata", mem_wdata,          32'h0);
        check("rst_ready",     {31'h0, req_ready}, 32'h1);
        rst = 1'b0;

        preload(6'd2,  32'h0000_000A);
        preload(6'd63, 32'h8000_0000);
        preload(6'd0,  32'h0000_0001);

        // LW aligned.
        run_op(1'b0, 3'b010, 8'h08, 32'h0, 1'b0);
        check("lw_lat",   lat, 32'd2);
        check("lw_rdata", rd, 32'h0000_000A);
        check("lw_err",   {31'h0, er}, 32'h0);
        check("lw_nrd",   nrd, 32'd1);
        check("lw_addr",  {26'h0, cyc_addr[1]}, 32'd2);
        check("lw_ready_in_resp", {31'h0, rdy_at_done}, 32'h0);

        // SB then LB / LBU of the same byte.
        run_op(1'b1, 3'b000, 8'h05, 32'h1234_56F0, 1'b0);
        check("sb_lat",   lat, 32'd2);
        check("sb_nwr",   nwr, 32'd1);
        check("sb_addr",  {26'h0, cyc_addr[1]}, 32'd1);
        check("sb_be",    {28'h0, cyc_be[1]}, 32'b0010);
        check("sb_lane1", {24'h0, cyc_wd[1][15:8]}, 32'hF0);
        check("sb_rdata", rd, 32'h0);
        run_op(1'b0, 3'b000, 8'h05, 32'h0, 1'b0);
        check("lb_rdata",  rd, 32'hFFFF_FFF0);
        run_op(1'b0, 3'b100, 8'h05, 32'h0, 1'b0);
        check("lbu_rdata", rd, 32'h0000_00F0);

        // SW crossing a word boundary, then LW back.
        run_op(1'b1, 3'b010, 8'h0E, 32'hAABB_CCDD, 1'b0);
        check("sw_lat",      lat, 32'd3);
        check("sw_nwr",      nwr, 32'd2);
        check("sw_addr1",    {26'h0, cyc_addr[1]}, 32'd3);
        check("sw_be1",      {28'h0, cyc_be[1]}, 32'b1100);
        check("sw_lanes1",   {16'h0, cyc_wd[1][31:16]}, 32'hCCDD);
        check("sw_addr2",    {26'h0, cyc_addr[2]}, 32'd4);
        check("sw_be2",      {28'h0, cyc_be[2]}, 32'b0011);
        check("sw_lanes2",   {16'h0, cyc_wd[2][15:0]}, 32'hAABB);
        run_op(1'b0, 3'b010, 8'h0E, 32'h0, 1'b0);
        check("lw_x_lat",    lat, 32'd3);
        check("lw_x_nrd",    nrd, 32'd2);
        check("lw_x_rdata",  rd, 32'hAABB_CCDD);

        // LH / LHU inside one word (upper half 0xCCDD).
        run_op(1'b0, 3'b001, 8'h0E, 32'h0, 1'b0);
        check("lh_lat",   lat, 32'd2);
        check("lh_rdata", rd, 32'hFFFF_CCDD);
        run_op(1'b0, 3'b101, 8'h0E, 32'h0, 1'b0);
        check("lhu_rdata", rd, 32'h0000_CCDD);

        // LH crossing the top of memory: word 63 wraps to word 0.
        run_op(1'b0, 3'b001, 8'hFF, 32'h0, 1'b0);
        check("lh_wrap_lat",   lat, 32'd3);
        check("lh_wrap_addr1", {26'h0, cyc_addr[1]}, 32'd63);
        check("lh_wrap_addr2", {26'h0, cyc_addr[2]}, 32'd0);
        check("lh_wrap_rdata", rd, 32'h0000_0180);

        // Illegal width codes.
        run_op(1'b0, 3'b011, 8'h08, 32'h0, 1'b0);
        check("ill_ld_lat",   lat, 32'd2);
        check("ill_ld_nrd",   nrd, 32'd0);
        check("ill_ld_err",   {31'h0, er}, 32'h1);
        check("ill_ld_rdata", rd, 32'h0);
        run_op(1'b0, 3'b111, 8'h0F, 32'h0, 1'b0);
        check("ill_ld_x_lat", lat, 32'd2);
        run_op(1'b1, 3'b101, 8'h10, 32'h5555_5555, 1'b0);
        check("ill_st_nwr",   nwr, 32'd0);
        check("ill_st_err",   {31'h0, er}, 32'h1);
        check("ill_st_lat",   lat, 32'd2);

        // req_valid held through RESP with changed inputs: captured request
        // is used, and nothing is accepted until IDLE.
        run_op(1'b0, 3'b010, 8'h08, 32'h0, 1'b1);
        check("hold_rdata",  rd, 32'h0000_000A);
        check("hold_addr",   {26'h0, cyc_addr[1]}, 32'd2);
        check("hold_ready_in_resp", {31'h0, rdy_at_done}, 32'h0);

        // Reset during ACC2 of a crossing SW.
        preload(6'd7, 32'h0000_0000);
        preload(6'd8, 32'hDEAD_BEEF);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        func3     = 3'b010;
        addr      = 8'h1E;
        wdata     = 32'h1122_3344;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rstacc_acc1_wr",   {31'h0, mem_write}, 32'h1);
        check("rstacc_acc1_addr", {26'h0, mem_addr}, 32'd7);
        @(posedge clk);
        #1;
        check("rstacc_acc2_addr", {26'h0, mem_addr}, 32'd8);
        rst = 1'b1;
        #1;
        check("rstacc_wr_gated", {31'h0, mem_write}, 32'h0);
        check("rstacc_be_gated", {28'h0, mem_be}, 32'h0);
        pulses = 0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        rst = 1'b0;
        check("rstacc_ready", {31'h0, req_ready}, 32'h1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("rstacc_no_done", pulses, 32'd0);
        check("rstacc_word7",   mem[7], 32'h3344_0000);
        check("rstacc_word8",   mem[8], 32'hDEAD_BEEF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter WORD_ADDR_W, default 6, giving the word-address width of the attached data memory (64 words).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req_valid, input, 1 bit: the pipeline presents a memory operation.
REQ-005 The block SHALL have port req_ready, output, 1 bit: high only in IDLE; a request is accepted when req_valid and req_ready are both high on a clock edge.
REQ-006 The block SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port func3, input, 3 bits: RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 The block SHALL have port addr, input, WORD_ADDR_W+2 bits: byte address.
REQ-009 The block SHALL have port wdata, input, 32 bits: store data, right-justified.
REQ-010 The block SHALL have port rdata, output, 32 bits: extended load result, valid while done is high.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port err, output, 1 bit: illegal func3 flag, valid while done is high.
REQ-013 The block SHALL have port mem_read, output, 1 bit: memory read enable.
REQ-014 The block SHALL have port mem_write, output, 1 bit: memory write enable.
REQ-015 The block SHALL have port mem_addr, output, WORD_ADDR_W bits: memory word address.
REQ-016 The block SHALL have port mem_be, output, 4 bits: per-byte write enables.
REQ-017 The block SHALL have port mem_wdata, output, 32 bits: lane-aligned write data.
REQ-018 The block SHALL have port mem_rdata, input, 32 bits: combinational read data for mem_addr.

Function
REQ-019 The block SHALL capture req_write, func3, addr and wdata on acceptance; inputs are ignored until the block returns to IDLE.
REQ-020 The state machine SHALL have states IDLE, ACC1, ACC2 and RESP, with transitions: IDLE->ACC1 on accept; ACC1->ACC2 if the access crosses a word boundary, else ACC1->RESP; ACC2->RESP; RESP->IDLE unconditionally.
REQ-021 An access SHALL count as crossing when it is W with addr[1:0]!=0, or H/HU with addr[1:0]==3.
REQ-022 In ACC1, mem_addr SHALL be addr[msb:2]; in ACC2 it SHALL be that value +1 modulo 2^WORD_ADDR_W (wrap from 63 to 0).
REQ-023 mem_read SHALL be high in ACC1/ACC2 for loads; mem_write SHALL be high in ACC1/ACC2 for stores; both SHALL be low in IDLE, RESP and for illegal requests.
REQ-024 For stores, mem_be and mem_wdata SHALL place the bytes of wdata at byte offsets addr[1:0] and up, with the overflow bytes written in ACC2 at lanes 0 and up.
REQ-025 For loads, the block SHALL latch mem_rdata in ACC1 (and ACC2), assemble the bytes starting at offset addr[1:0], sign-extend B/H, and zero-extend BU/HU.
REQ-026 Latency SHALL be: done two cycles after accept for a non-crossing access and three cycles after accept for a crossing access.
REQ-027 rdata SHALL be 0 for stores and for illegal requests.
REQ-028 func3 011/110/111 on any access, and 100/101 on a store, SHALL go IDLE->ACC1->RESP with no memory enables, and assert err with done.
REQ-029 req_valid during RESP SHALL NOT be accepted; it is accepted at the following edge in IDLE.

Reset
REQ-030 While rst is high the block SHALL go to IDLE, and req_ready SHALL be 1 from the next cycle.
REQ-031 While rst is high, done, err, rdata, mem_read, mem_write, mem_addr, mem_be and mem_wdata SHALL all be 0.
REQ-032 Reset during ACC2 of a store SHALL abort the ACC2 write; the bytes already written in ACC1 SHALL stay in memory.

Structure
REQ-033 The func3 codes and the state enumeration SHALL live in a shared package, lsu_pkg.
REQ-034 The byte-lane shift/extend logic SHALL be a sub-module named byte_lane_align, used for both store alignment and load assembly.

Verification
REQ-035 LW at addr 0x08 with word 2 = 0x0000000A -> done at accept+2, rdata 0x0000000A, one mem_read cycle at mem_addr 2.
REQ-036 SB wdata 0x123456F0 at addr 0x05 -> one write, mem_addr 1, mem_be 0010, mem_wdata[15:8]=0xF0; a following LB at 0x05 returns 0xFFFFFFF0 and an LBU returns 0x000000F0.
REQ-037 SW 0xAABBCCDD at addr 0x0E -> ACC1 mem_addr 3, be 1100, lanes 3:2 = AABB? no: lane2=0xDD, lane3=0xCC; ACC2 mem_addr 4, be 0011, lane0=0xBB, lane1=0xAA; a following LW at 0x0E returns 0xAABBCCDD at accept+3.
REQ-038 LH at addr 0xFF (word 63 byte 3 = 0x80, word 0 byte 0 = 0x01) -> ACC2 mem_addr wraps to 0, rdata 0x00000180.
REQ-039 func3 011 load -> no mem_read, done at accept+2 with err=1 and rdata 0; SH with func3 101 -> no mem_write, err=1.
REQ-040 rst asserted in ACC2 of a crossing SW -> no write in ACC2, done never pulses, req_ready=1 after reset releases, and the ACC1 bytes remain in memory.
